ssp_cmd_master: RTL and testbench
=================================

Name: ssp_cmd_master

Overview:
- Upstream command stage for ssp_uart. It turns queued host register requests into SSP bus transactions.
- Buffers commands in a small FIFO and drives SSP_SSEL / SSP_EOC / SSP_RA / SSP_WnR / SSP_DI one transaction at a time.
- Samples SSP_DO at end of each transaction and returns it through a valid/ready response port.
- Replaces ad-hoc testbench pin driving with a synthesizable, back-pressured master.

Parameters:
- DATA_W, 12, SSP data width (SSP_DI/SSP_DO/Cmd_DI/Rsp_Data).
- ADDR_W, 3, SSP register address width.
- CMD_DEPTH, 4, command FIFO depth; power of 2, minimum 2.
- HOLD_CYCLES, 2, cycles SSP_SSEL is held per transaction; minimum 1.

Ports:
- Clk  in  1  single clock for the whole block.
- Rst  in  1  reset, synchronous, active-low.
- Cmd_Valid  in  1  host command valid.
- Cmd_Ready  out  1  FIFO can accept; equals !full.
- Cmd_WnR  in  1  1 = write, 0 = read.
- Cmd_RA  in  ADDR_W  target register address.
- Cmd_DI  in  DATA_W  write data; ignored for reads.
- Rsp_Valid  out  1  response available.
- Rsp_Ready  in  1  host accepts response.
- Rsp_Data  out  DATA_W  SSP_DO captured for this transaction.
- Rsp_RA  out  ADDR_W  address of the completed command.
- Rsp_WnR  out  1  type of the completed command.
- SSP_SSEL  out  1  slave select to ssp_uart.
- SSP_EOC  out  1  end-of-cycle strobe to ssp_uart.
- SSP_WnR  out  1  transaction direction.
- SSP_RA  out  ADDR_W  register address.
- SSP_DI  out  DATA_W  write data.
- SSP_DO  in  DATA_W  read data from ssp_uart.
- Busy  out  1  FSM not in IDLE, or FIFO non-empty.
- Cmd_Count  out  clog2(CMD_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: Rst=0 at a rising edge clears everything.
  - All outputs read 0 after that edge, except Cmd_Ready, which reads 1.
  - FIFO is emptied, FSM goes to IDLE, and any in-flight transaction or pending response is dropped. SSP_SSEL is low after that edge.
- FIFO push: on an edge with Cmd_Valid && Cmd_Ready.
  - Cmd_Ready is registered and derived from the current count, so no push occurs when full.
  - Push and pop on the same edge are legal; count is unchanged.
- All SSP_* outputs are registered.
- FSM state IDLE: SSP_* outputs are all 0.
  - If the FIFO is non-empty at an edge: pop the head, load SSP_RA/SSP_WnR/SSP_DI, set SSP_SSEL=1, load the hold counter to HOLD_CYCLES-1, and go to XFER.
  - A command pushed at edge k into an empty FIFO has SSP_SSEL high from edge k+1. There is no bypass.
- FSM state XFER: SSP_SSEL stays 1; SSP_RA/SSP_WnR/SSP_DI are stable.
  - SSP_EOC=1 only during the final hold cycle (counter==0). With HOLD_CYCLES=1, SSP_EOC rises together with SSP_SSEL.
  - At the edge ending the final cycle: capture SSP_DO into Rsp_Data, copy RA/WnR to Rsp_RA/Rsp_WnR, set Rsp_Valid=1, drop SSEL/EOC, and go to RSP.
  - The counter decrements each edge otherwise.
- FSM state RSP: Rsp_Valid held until Rsp_Ready.
  - Rsp_Data/Rsp_RA/Rsp_WnR are stable while Rsp_Valid=1.
  - At an edge with Rsp_Ready=1: clear Rsp_Valid and go to GAP.
  - The FIFO continues to accept commands while RSP is stalled.
- FSM state GAP: one cycle with SSEL low between transactions, then IDLE. Minimum SSEL-low time is 2 cycles.
- Every command, read or write, produces exactly one response, in FIFO order.
- For writes, Rsp_Data is the readback present on SSP_DO at the capture edge.
- Throughput: one transaction per HOLD_CYCLES+3 cycles when Rsp_Ready is tied high.
- Busy = (state != IDLE) || (Cmd_Count != 0).
- Pointers wrap modulo CMD_DEPTH. Count never exceeds CMD_DEPTH or underflows.
- Cmd_* inputs are sampled only on the push edge. Changes while Cmd_Ready=0 have no effect.

Test Plan:
- Single write (RA=0, DI=DED, WnR=1) at edge k, ssp_uart attached, Rsp_Ready=1 -> SSEL high for edges k+1..k+2; EOC only in the cycle after edge k+2; Rsp_Valid at edge k+3 with Rsp_Data=DED, Rsp_RA=0, Rsp_WnR=1.
- Write 0/ABC then read RA=0 -> the read transaction shows SSP_WnR=0; its response has Rsp_Data=ABC and Rsp_WnR=0; responses arrive in order.
- Push 5 commands back-to-back with Rsp_Ready=0 -> 1 pops, 4 fill the FIFO (Cmd_Count=4), Cmd_Ready=0, Rsp_Valid held with stable data. Raising Rsp_Ready drains all 5 in order with a ≥2-cycle SSEL gap between transactions.
- Hold Rsp_Ready=0 for 10 cycles -> Rsp_Data/RA/WnR unchanged; no new SSEL assertion until the response is accepted.
- Assert Rst=0 for one edge during XFER with 2 commands queued -> next cycle SSEL=0, Rsp_Valid=0, Cmd_Count=0, Cmd_Ready=1, Busy=0. No response is ever produced for the aborted command.
- HOLD_CYCLES=1 and HOLD_CYCLES=4 builds -> SSEL width 1 and 4 cycles respectively; EOC exactly 1 cycle, coincident with the last SSEL cycle.

Source files
------------

// File: rtl/ssp_cmd_master_if.sv
// Host command/response and SSP bus signals of ssp_cmd_master.
// The master modport is the command-master view; slave is the host/ssp_uart side.
interface ssp_cmd_master_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
);
  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic              Cmd_WnR;
  logic [ADDR_W-1:0] Cmd_RA;
  logic [DATA_W-1:0] Cmd_DI;

  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic [DATA_W-1:0] Rsp_Data;
  logic [ADDR_W-1:0] Rsp_RA;
  logic              Rsp_WnR;

  logic              SSP_SSEL;
  logic              SSP_EOC;
  logic              SSP_WnR;
  logic [ADDR_W-1:0] SSP_RA;
  logic [DATA_W-1:0] SSP_DI;
  logic [DATA_W-1:0] SSP_DO;

  modport master (
    input  Cmd_Valid, Cmd_WnR, Cmd_RA, Cmd_DI, Rsp_Ready, SSP_DO,
    output Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_RA, Rsp_WnR,
           SSP_SSEL, SSP_EOC, SSP_WnR, SSP_RA, SSP_DI
  );

  modport slave (
    output Cmd_Valid, Cmd_WnR, Cmd_RA, Cmd_DI, Rsp_Ready, SSP_DO,
    input  Cmd_Ready, Rsp_Valid, Rsp_Data, Rsp_RA, Rsp_WnR,
           SSP_SSEL, SSP_EOC, SSP_WnR, SSP_RA, SSP_DI
  );
endinterface

// File: rtl/ssp_cmd_master.sv
// Buffers host register commands in a FIFO and runs them as SSP transactions,
// returning captured SSP_DO on a valid/ready response port.
module ssp_cmd_master #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 3,
  parameter int CMD_DEPTH   = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  ssp_cmd_master_if.master            bus,
  output logic                        Busy,
  output logic [$clog2(CMD_DEPTH):0]  Cmd_Count
);
  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int HCNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, XFER, RSP, GAP} state_t;

  state_t state_q, state_n;

  logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_n;
  logic               cmd_ready_q;
  logic               push, pop;

  logic              head_wnr;
  logic [ADDR_W-1:0] head_ra;
  logic [DATA_W-1:0] head_di;

  logic [HCNT_W-1:0] hold_q, hold_n;
  logic              ssel_q, ssel_n;
  logic              eoc_q, eoc_n;
  logic              swnr_q, swnr_n;
  logic [ADDR_W-1:0] sra_q, sra_n;
  logic [DATA_W-1:0] sdi_q, sdi_n;

  logic              rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_n;
  logic [ADDR_W-1:0] rsp_ra_q, rsp_ra_n;
  logic              rsp_wnr_q, rsp_wnr_n;

  assign push    = bus.Cmd_Valid && cmd_ready_q;
  assign count_n = count_q + CNT_W'(push) - CNT_W'(pop);
  assign {head_wnr, head_ra, head_di} = fifo_mem[rd_ptr_q];

  // Storage needs no reset: only entries behind the reset pointers are ever read.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.Cmd_WnR, bus.Cmd_RA, bus.Cmd_DI};
  end

  always_comb begin
    state_n     = state_q;
    pop         = 1'b0;
    hold_n      = hold_q;
    ssel_n      = ssel_q;
    eoc_n       = eoc_q;
    swnr_n      = swnr_q;
    sra_n       = sra_q;
    sdi_n       = sdi_q;
    rsp_valid_n = rsp_valid_q;
    rsp_data_n  = rsp_data_q;
    rsp_ra_n    = rsp_ra_q;
    rsp_wnr_n   = rsp_wnr_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          swnr_n  = head_wnr;
          sra_n   = head_ra;
          sdi_n   = head_di;
          ssel_n  = 1'b1;
          eoc_n   = (HOLD_CYCLES == 1);
          hold_n  = HCNT_W'(HOLD_CYCLES - 1);
          state_n = XFER;
        end
      end
      XFER: begin
        if (hold_q == '0) begin
          rsp_valid_n = 1'b1;
          rsp_data_n  = bus.SSP_DO;
          rsp_ra_n    = sra_q;
          rsp_wnr_n   = swnr_q;
          ssel_n      = 1'b0;
          eoc_n       = 1'b0;
          swnr_n      = 1'b0;
          sra_n       = '0;
          sdi_n       = '0;
          state_n     = RSP;
        end else begin
          hold_n = hold_q - HCNT_W'(1);
          // EOC is registered, so it rises one edge ahead of the last hold cycle.
          eoc_n  = (hold_q == HCNT_W'(1));
        end
      end
      RSP: begin
        if (bus.Rsp_Ready) begin
          rsp_valid_n = 1'b0;
          state_n     = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      hold_q      <= '0;
      ssel_q      <= 1'b0;
      eoc_q       <= 1'b0;
      swnr_q      <= 1'b0;
      sra_q       <= '0;
      sdi_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ra_q    <= '0;
      rsp_wnr_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_n;
      cmd_ready_q <= (count_n != CNT_W'(CMD_DEPTH));
      hold_q      <= hold_n;
      ssel_q      <= ssel_n;
      eoc_q       <= eoc_n;
      swnr_q      <= swnr_n;
      sra_q       <= sra_n;
      sdi_q       <= sdi_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_ra_q    <= rsp_ra_n;
      rsp_wnr_q   <= rsp_wnr_n;
    end
  end

  assign bus.Cmd_Ready = cmd_ready_q;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_Data  = rsp_data_q;
  assign bus.Rsp_RA    = rsp_ra_q;
  assign bus.Rsp_WnR   = rsp_wnr_q;
  assign bus.SSP_SSEL  = ssel_q;
  assign bus.SSP_EOC   = eoc_q;
  assign bus.SSP_WnR   = swnr_q;
  assign bus.SSP_RA    = sra_q;
  assign bus.SSP_DI    = sdi_q;

  assign Busy      = (state_q != IDLE) || (count_q != '0);
  assign Cmd_Count = count_q;
endmodule

// File: tb/tb_ssp_cmd_master.sv
// Directed bench for ssp_cmd_master: cycle table for basic transactions, then
// FIFO fill/back-pressure, reset abort and HOLD_CYCLES=1/4 pulse-shape sequences.
module tb_ssp_cmd_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssp_cmd_master_if #(.DATA_W(12), .ADDR_W(3)) if_m ();
  ssp_cmd_master_if #(.DATA_W(12), .ADDR_W(3)) if_h1 ();
  ssp_cmd_master_if #(.DATA_W(12), .ADDR_W(3)) if_h4 ();

  logic       busy_m, busy_h1, busy_h4;
  logic [2:0] cnt_m, cnt_h1, cnt_h4;

  ssp_cmd_master #(.DATA_W(12), .ADDR_W(3), .CMD_DEPTH(4), .HOLD_CYCLES(2)) u_dut (
    .Clk(clk), .Rst(rst), .bus(if_m), .Busy(busy_m), .Cmd_Count(cnt_m));
  ssp_cmd_master #(.DATA_W(12), .ADDR_W(3), .CMD_DEPTH(4), .HOLD_CYCLES(1)) u_h1 (
    .Clk(clk), .Rst(rst), .bus(if_h1), .Busy(busy_h1), .Cmd_Count(cnt_h1));
  ssp_cmd_master #(.DATA_W(12), .ADDR_W(3), .CMD_DEPTH(4), .HOLD_CYCLES(4)) u_h4 (
    .Clk(clk), .Rst(rst), .bus(if_h4), .Busy(busy_h4), .Cmd_Count(cnt_h4));

  // Minimal ssp_uart stand-in: register file written on EOC, writes read back DI.
  logic [11:0] sregs [8];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) sregs[i] <= '0;
    end else if (if_m.SSP_SSEL && if_m.SSP_EOC && if_m.SSP_WnR) begin
      sregs[if_m.SSP_RA] <= if_m.SSP_DI;
    end
  end
  assign if_m.SSP_DO  = (if_m.SSP_SSEL && if_m.SSP_WnR) ? if_m.SSP_DI : sregs[if_m.SSP_RA];
  assign if_h1.SSP_DO = 12'h5A5;
  assign if_h4.SSP_DO = 12'h5A5;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic wnr, input logic [2:0] ra,
                           input logic [11:0] di);
    if_m.Cmd_Valid = v;
    if_m.Cmd_WnR   = wnr;
    if_m.Cmd_RA    = ra;
    if_m.Cmd_DI    = di;
  endtask

  typedef struct {
    logic        rst, v, wnr;
    logic [2:0]  ra;
    logic [11:0] di;
    logic        rr;
    logic        ssel, eoc, swnr, rv;
    logic [11:0] rdata;
    logic        rwnr;
    logic [2:0]  rra;
    logic [2:0]  cnt;
    logic        crdy, busy;
  } vec_t;

  function automatic vec_t mkv(input logic rst, v, wnr, input logic [2:0] ra,
                               input logic [11:0] di, input logic rr,
                               input logic ssel, eoc, swnr, rv, input logic [11:0] rdata,
                               input logic rwnr, input logic [2:0] rra, input logic [2:0] cnt,
                               input logic crdy, busy);
    vec_t t;
    t.rst = rst; t.v = v; t.wnr = wnr; t.ra = ra; t.di = di; t.rr = rr;
    t.ssel = ssel; t.eoc = eoc; t.swnr = swnr; t.rv = rv; t.rdata = rdata;
    t.rwnr = rwnr; t.rra = rra; t.cnt = cnt; t.crdy = crdy; t.busy = busy;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0]  f_ra   [5];
    logic        f_wnr  [5];
    logic [11:0] f_di   [5];
    logic [11:0] f_exp  [5];
    logic [2:0]  f_cnt  [5];
    logic        f_crdy [5];
    int got, rises, low_run, min_gap, bad;
    logic prev_ssel;
    int w1, w4, e1, e4, b1, b4;
    logic p1s, p1e, p4s, p4e;

    rst = 1'b0;
    drive_cmd(1'b0, 1'b0, 3'd0, 12'h000);
    if_m.Rsp_Ready  = 1'b1;
    if_h1.Cmd_Valid = 1'b0; if_h1.Cmd_WnR = 1'b0; if_h1.Cmd_RA = '0; if_h1.Cmd_DI = '0;
    if_h4.Cmd_Valid = 1'b0; if_h4.Cmd_WnR = 1'b0; if_h4.Cmd_RA = '0; if_h4.Cmd_DI = '0;
    if_h1.Rsp_Ready = 1'b1;
    if_h4.Rsp_Ready = 1'b1;

    //                 rst v  wnr ra    di       rr | ssel eoc swnr rv  rdata    rwnr rra  cnt  crdy busy
    vecs.push_back(mkv(0, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 0));
    vecs.push_back(mkv(1, 1, 1, 3'd0, 12'hDED, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   1,   0,  1,   0, 12'h000, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   1,   1,  1,   0, 12'h000, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   1, 12'hDED, 1,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 0));
    vecs.push_back(mkv(1, 1, 1, 3'd0, 12'hABC, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 1, 0, 3'd0, 12'h000, 1,   1,   0,  1,   0, 12'h000, 0,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   1,   1,  1,   0, 12'h000, 0,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   1, 12'hABC, 1,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd1, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   1,   0,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   1,   1,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   1, 12'hABC, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 1));
    vecs.push_back(mkv(1, 0, 0, 3'd0, 12'h000, 1,   0,   0,  0,   0, 12'h000, 0,   3'd0, 3'd0, 1, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      drive_cmd(vecs[i].v, vecs[i].wnr, vecs[i].ra, vecs[i].di);
      if_m.Rsp_Ready = vecs[i].rr;
      tick();
      chk($sformatf("v%0d.ssel", i), 32'(if_m.SSP_SSEL), 32'(vecs[i].ssel));
      chk($sformatf("v%0d.eoc", i), 32'(if_m.SSP_EOC), 32'(vecs[i].eoc));
      chk($sformatf("v%0d.ssp_wnr", i), 32'(if_m.SSP_WnR), 32'(vecs[i].swnr));
      chk($sformatf("v%0d.rsp_valid", i), 32'(if_m.Rsp_Valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d.cmd_count", i), 32'(cnt_m), 32'(vecs[i].cnt));
      chk($sformatf("v%0d.cmd_ready", i), 32'(if_m.Cmd_Ready), 32'(vecs[i].crdy));
      chk($sformatf("v%0d.busy", i), 32'(busy_m), 32'(vecs[i].busy));
      if (vecs[i].rv || !vecs[i].rst) begin
        chk($sformatf("v%0d.rsp_data", i), 32'(if_m.Rsp_Data), 32'(vecs[i].rdata));
        chk($sformatf("v%0d.rsp_wnr", i), 32'(if_m.Rsp_WnR), 32'(vecs[i].rwnr));
        chk($sformatf("v%0d.rsp_ra", i), 32'(if_m.Rsp_RA), 32'(vecs[i].rra));
        chk($sformatf("v%0d.ssp_ra", i), 32'(if_m.SSP_RA), 32'(3'd0));
      end
    end

    // Five back-to-back commands with the response port stalled.
    f_wnr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    f_ra  = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd2};
    f_di  = '{12'h111, 12'h000, 12'h222, 12'h000, 12'h000};
    f_exp = '{12'h111, 12'h111, 12'h222, 12'hABC, 12'h222};
    f_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    f_crdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_m.Rsp_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, f_wnr[i], f_ra[i], f_di[i]);
      tick();
      chk($sformatf("fill%0d.count", i), 32'(cnt_m), 32'(f_cnt[i]));
      chk($sformatf("fill%0d.cmd_ready", i), 32'(if_m.Cmd_Ready), 32'(f_crdy[i]));
    end
    drive_cmd(1'b1, 1'b1, 3'd3, 12'hFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("full%0d.count", i), 32'(cnt_m), 32'(3'd4));
      chk($sformatf("full%0d.cmd_ready", i), 32'(if_m.Cmd_Ready), 32'(1'b0));
    end
    drive_cmd(1'b0, 1'b0, 3'd0, 12'h000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall%0d.rsp", i),
          {16'h0, if_m.Rsp_Valid, if_m.SSP_SSEL, if_m.Rsp_WnR, if_m.Rsp_RA, if_m.Rsp_Data},
          {16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 12'h111});
    end

    if_m.Rsp_Ready = 1'b1;
    got = 0; rises = 0; low_run = 0; min_gap = 99; prev_ssel = 1'b0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (if_m.SSP_SSEL) begin
        if (!prev_ssel) begin
          rises++;
          if (low_run < min_gap) min_gap = low_run;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_ssel = if_m.SSP_SSEL;
      if (if_m.Rsp_Valid) begin
        chk($sformatf("drain%0d.data", got), 32'(if_m.Rsp_Data), 32'(f_exp[got]));
        chk($sformatf("drain%0d.ra", got), 32'(if_m.Rsp_RA), 32'(f_ra[got]));
        chk($sformatf("drain%0d.wnr", got), 32'(if_m.Rsp_WnR), 32'(f_wnr[got]));
        got++;
      end
      tick();
    end
    chk("drain.responses", 32'(got), 32'd5);
    chk("drain.ssel_rises", 32'(rises), 32'd4);
    chk("drain.min_ssel_gap_ge2", 32'(min_gap >= 2), 32'd1);
    tick(); tick();
    chk("drain.idle_busy", 32'(busy_m), 32'd0);
    chk("drain.idle_count", 32'(cnt_m), 32'd0);

    // Reset while a transaction is in flight with two commands queued.
    drive_cmd(1'b1, 1'b1, 3'd4, 12'h444); tick();
    drive_cmd(1'b1, 1'b1, 3'd5, 12'h555); tick();
    drive_cmd(1'b1, 1'b1, 3'd6, 12'h666); tick();
    chk("abort.pre_ssel", 32'(if_m.SSP_SSEL), 32'd1);
    chk("abort.pre_count", 32'(cnt_m), 32'd2);
    drive_cmd(1'b0, 1'b0, 3'd0, 12'h000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort.ssel", 32'(if_m.SSP_SSEL), 32'd0);
    chk("abort.eoc", 32'(if_m.SSP_EOC), 32'd0);
    chk("abort.rsp_valid", 32'(if_m.Rsp_Valid), 32'd0);
    chk("abort.count", 32'(cnt_m), 32'd0);
    chk("abort.cmd_ready", 32'(if_m.Cmd_Ready), 32'd1);
    chk("abort.busy", 32'(busy_m), 32'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if_m.Rsp_Valid || if_m.SSP_SSEL || cnt_m != 3'd0) bad++;
    end
    chk("abort.no_activity", 32'(bad), 32'd0);

    // SSEL/EOC shape on HOLD_CYCLES=1 and HOLD_CYCLES=4 builds.
    if_h1.Cmd_Valid = 1'b1; if_h1.Cmd_RA = 3'd3;
    if_h4.Cmd_Valid = 1'b1; if_h4.Cmd_RA = 3'd3;
    tick();
    if_h1.Cmd_Valid = 1'b0;
    if_h4.Cmd_Valid = 1'b0;
    w1 = 0; w4 = 0; e1 = 0; e4 = 0; b1 = 0; b4 = 0;
    p1s = 1'b0; p1e = 1'b0; p4s = 1'b0; p4e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_h1.SSP_SSEL) w1++;
      if (if_h1.SSP_EOC) e1++;
      if ((if_h1.SSP_EOC && !if_h1.SSP_SSEL) || (p1e && if_h1.SSP_SSEL) ||
          (p1s && !if_h1.SSP_SSEL && !p1e)) b1++;
      p1s = if_h1.SSP_SSEL; p1e = if_h1.SSP_EOC;
      if (if_h4.SSP_SSEL) w4++;
      if (if_h4.SSP_EOC) e4++;
      if ((if_h4.SSP_EOC && !if_h4.SSP_SSEL) || (p4e && if_h4.SSP_SSEL) ||
          (p4s && !if_h4.SSP_SSEL && !p4e)) b4++;
      p4s = if_h4.SSP_SSEL; p4e = if_h4.SSP_EOC;
      tick();
    end
    chk("hold1.ssel_width", 32'(w1), 32'd1);
    chk("hold1.eoc_width", 32'(e1), 32'd1);
    chk("hold1.eoc_alignment", 32'(b1), 32'd0);
    chk("hold4.ssel_width", 32'(w4), 32'd4);
    chk("hold4.eoc_width", 32'(e4), 32'd1);
    chk("hold4.eoc_alignment", 32'(b4), 32'd0);
    chk("hold1.idle", {29'h0, busy_h1, cnt_h1[1:0]}, 32'd0);
    chk("hold4.idle", {29'h0, busy_h4, cnt_h4[1:0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
